// File: rtl/traffic_light_pkg.sv
// -----------------------------------------------------------------------------
// traffic_light_pkg
// Shared definitions for the traffic light monitor: one-hot light codes,
// tracked phase encoding and small decode helpers.
//   LIGHT_RED/LIGHT_YELLOW/LIGHT_GREEN : one-hot light codes (bit2/bit1/bit0)
//   phase_e                            : 2-bit tracked phase per direction
//   code_valid()                       : true for exactly one of the three codes
//   decode_phase()                     : light code -> phase (UNKNOWN if invalid)
// -----------------------------------------------------------------------------
package traffic_light_pkg;

    localparam logic [2:0] LIGHT_RED    = 3'b100;
    localparam logic [2:0] LIGHT_YELLOW = 3'b010;
    localparam logic [2:0] LIGHT_GREEN  = 3'b001;

    typedef enum logic [1:0] {
        PH_UNKNOWN = 2'd0,
        PH_RED     = 2'd1,
        PH_GREEN   = 2'd2,
        PH_YELLOW  = 2'd3
    } phase_e;

    function automatic logic code_valid(input logic [2:0] code);
        return (code == LIGHT_RED) || (code == LIGHT_YELLOW) || (code == LIGHT_GREEN);
    endfunction

    function automatic phase_e decode_phase(input logic [2:0] code);
        phase_e ph;
        case (code)
            LIGHT_RED:    ph = PH_RED;
            LIGHT_YELLOW: ph = PH_YELLOW;
            LIGHT_GREEN:  ph = PH_GREEN;
            default:      ph = PH_UNKNOWN;
        endcase
        return ph;
    endfunction

endpackage

// File: rtl/light_phase_tracker.sv
// -----------------------------------------------------------------------------
// light_phase_tracker
// Tracks the phase of one light direction, its dwell time and the number of
// completed GREEN->YELLOW->RED cycles. The error outputs are combinational
// detections for the sample currently on light_i; the parent registers them.
// Ports:
//   clk          in   rising-edge clock
//   reset        in   asynchronous active-low reset
//   light_i      in   3-bit one-hot light code
//   state_o      out  tracked phase (registered)
//   cycles_o     out  completed cycle count, wraps (registered)
//   seq_err_o    out  illegal transition in current sample
//   dwell_err_o  out  GREEN too short / YELLOW wrong length on leaving
//   code_err_o   out  non-one-hot code in current sample
// -----------------------------------------------------------------------------
module light_phase_tracker
    import traffic_light_pkg::*;
#(
    parameter int MIN_GREEN  = 5,
    parameter int YELLOW_CYC = 1,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       light_i,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] cycles_o,
    output logic             seq_err_o,
    output logic             dwell_err_o,
    output logic             code_err_o
);

    localparam logic [CNT_W-1:0] MIN_G_CNT  = CNT_W'(MIN_GREEN);
    localparam logic [CNT_W-1:0] YEL_CNT    = CNT_W'(YELLOW_CYC);
    localparam logic [CNT_W-1:0] DWELL_ONE  = CNT_W'(1);

    phase_e           state_q, state_d;
    logic [CNT_W-1:0] dwell_q, dwell_d;
    logic [CNT_W-1:0] cycles_q, cycles_d;
    phase_e           obs;

    // NOTE: every output of this block gets a default first, so no path
    // through the if/else chain can leave a value unassigned and infer a latch.
    always_comb begin
        state_d     = state_q;
        dwell_d     = dwell_q;
        cycles_d    = cycles_q;
        seq_err_o   = 1'b0;
        dwell_err_o = 1'b0;
        code_err_o  = 1'b0;
        obs         = decode_phase(light_i);

        if (!code_valid(light_i)) begin
            code_err_o = 1'b1;
            state_d    = PH_UNKNOWN;
            dwell_d    = '0;
        end else if (state_q == PH_UNKNOWN) begin
            // Entering from UNKNOWN is always accepted without any checks.
            state_d = obs;
            dwell_d = DWELL_ONE;
        end else if (obs == state_q) begin
            if (dwell_q != '1) dwell_d = dwell_q + DWELL_ONE;
        end else begin
            // Any phase change restarts dwell; dwell is only judged on legal moves.
            state_d = obs;
            dwell_d = DWELL_ONE;
            if (state_q == PH_GREEN && obs == PH_YELLOW) begin
                dwell_err_o = (dwell_q < MIN_G_CNT);
            end else if (state_q == PH_YELLOW && obs == PH_RED) begin
                dwell_err_o = (dwell_q != YEL_CNT);
                cycles_d    = cycles_q + DWELL_ONE;
            end else if (!(state_q == PH_RED && obs == PH_GREEN)) begin
                seq_err_o = 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers
    // update together from values sampled before the edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= PH_UNKNOWN;
            dwell_q  <= '0;
            cycles_q <= '0;
        end else begin
            state_q  <= state_d;
            dwell_q  <= dwell_d;
            cycles_q <= cycles_d;
        end
    end

    assign state_o  = state_q;
    assign cycles_o = cycles_q;

endmodule

// File: rtl/traffic_light_monitor.sv
// -----------------------------------------------------------------------------
// traffic_light_monitor
// Synthesizable checker for a two-direction traffic light interface. Tracks
// each direction's phase, counts completed cycles and flags conflicts, illegal
// transitions, dwell violations and invalid codes one cycle after the sample.
// Configuration macro: STICKY_ERR_EN - when defined every err_* latches high
// until reset; otherwise err_* are single-cycle pulses.
// Ports:
//   clk, reset               clock, asynchronous active-low reset
//   light_A, light_B         3-bit one-hot light codes (R/Y/G = bit2/1/0)
//   state_A, state_B         tracked phase: 0 UNKNOWN, 1 RED, 2 GREEN, 3 YELLOW
//   err_conflict             both directions valid and non-RED
//   err_seq_A/B              illegal phase transition
//   err_dwell_A/B            GREEN too short or YELLOW wrong length
//   err_code_A/B             non-one-hot code
//   cycles_A/B               completed G->Y->R cycles, wraps
// -----------------------------------------------------------------------------
module traffic_light_monitor
    import traffic_light_pkg::*;
#(
    parameter int MIN_GREEN  = 5,
    parameter int YELLOW_CYC = 1,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       light_A,
    input  logic [2:0]       light_B,
    output logic [1:0]       state_A,
    output logic [1:0]       state_B,
    output logic             err_conflict,
    output logic             err_seq_A,
    output logic             err_seq_B,
    output logic             err_dwell_A,
    output logic             err_dwell_B,
    output logic             err_code_A,
    output logic             err_code_B,
    output logic [CNT_W-1:0] cycles_A,
    output logic [CNT_W-1:0] cycles_B
);

    logic seq_a, seq_b, dwell_a, dwell_b, code_a, code_b, conflict;
    logic [6:0] det, err_d, err_q;

    light_phase_tracker #(.MIN_GREEN(MIN_GREEN), .YELLOW_CYC(YELLOW_CYC), .CNT_W(CNT_W)) u_trk_a (
        .clk         (clk),
        .reset       (reset),
        .light_i     (light_A),
        .state_o     (state_A),
        .cycles_o    (cycles_A),
        .seq_err_o   (seq_a),
        .dwell_err_o (dwell_a),
        .code_err_o  (code_a)
    );

    light_phase_tracker #(.MIN_GREEN(MIN_GREEN), .YELLOW_CYC(YELLOW_CYC), .CNT_W(CNT_W)) u_trk_b (
        .clk         (clk),
        .reset       (reset),
        .light_i     (light_B),
        .state_o     (state_B),
        .cycles_o    (cycles_B),
        .seq_err_o   (seq_b),
        .dwell_err_o (dwell_b),
        .code_err_o  (code_b)
    );

    // Conflict looks at the raw samples, independent of tracked phase.
    assign conflict = code_valid(light_A) && code_valid(light_B) &&
                      (light_A != LIGHT_RED) && (light_B != LIGHT_RED);

    assign det = {conflict, seq_a, seq_b, dwell_a, dwell_b, code_a, code_b};

    always_comb begin
`ifdef STICKY_ERR_EN
        err_d = err_q | det;
`else
        err_d = det;
`endif
    end

    // NOTE: only control/flag registers exist here, so all of them take the
    // asynchronous reset; nothing is memory-like that could skip it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) err_q <= '0;
        else        err_q <= err_d;
    end

    assign {err_conflict, err_seq_A, err_seq_B, err_dwell_A,
            err_dwell_B, err_code_A, err_code_B} = err_q;

endmodule
